bcd_round_timer: RTL
====================

# bcd_round_timer

Parametrised multi-digit BCD round timer that drives the board's seven-segment digits, the round-count LED bar, the run/pause status LEDs and the breath LED. It counts up or down between 0 and a preset selected from four parameter values. Each wrap completes one round, and the timer stops after a configurable number of rounds. The block is fully synchronous to the board clock and sits directly behind the push-button and switch inputs at top level.

## Interface
- TICK_DIV, 6000000, clock cycles per count step in normal speed (1 s at 6 MHz)
- FAST_DIV, 1500000, clock cycles per count step when `fast`=1
- DIGITS, 2, number of BCD digits (1..4)
- ROUNDS, 8, rounds before DONE (1..8); also the width of `count_led`
- PRESET0/1/2/3, 'h10/'h24/'h60/'h99, BCD presets selected by `set`, each 4*DIGITS wide
- BREATH_STEPS, 4800, breath PWM period in clocks and the number of duty steps
- clk  in  1  board clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pause/run button; asynchronous input
- recount  in  1  direction: 0 = up, 1 = down; level input
- set  in  2  preset select; level input
- fast  in  1  1 selects FAST_DIV
- seg_led  out  9*DIGITS  per digit {2'b00, gfedcba}, active-high; digit 0 (ones) in bits [8:0]
- count_led  out  ROUNDS  active-low thermometer of completed rounds
- status_led_r, status_led_g  out  1 each  status indication
- done  out  1  high in DONE
- breath_led  out  1  active-low breathing LED

## Operation
- `start`, `recount`, `set` and `fast` each pass through a 2-flop synchronizer. `start` is rising-edge detected after synchronization.
- State machine:
  - PAUSE (reset state): the count is held and the divider is held at 0. A start edge moves to RUN.
  - RUN: the divider counts 0..DIV-1 and emits a one-cycle tick at DIV-1. A start edge moves to PAUSE. Completing round ROUNDS moves to DONE.
  - DONE: the count and rounds are held. A start edge reloads the start value, clears rounds and moves to RUN.
- Start value: 0 in up mode; the selected preset in down mode.
- Up mode: on each tick, a count equal to the preset wraps to 0 and increments rounds. Otherwise the count does a BCD increment with per-digit carry.
- Down mode: on each tick, a count of 0 reloads the preset and increments rounds. Otherwise the count does a BCD decrement with per-digit borrow.
- Preset digits greater than 9 are clamped to 9 per digit. A preset of 0 wraps on every tick.
- A change of synchronized `recount` or `set` in any state does all of the following in the next cycle: reload the start value, clear rounds, clear the divider, and enter PAUSE.
- A change of synchronized `fast` clears the divider only.
- count_led bit i is 0 when i < rounds.
- Status outputs:
  - RUN: r=1, g=0
  - PAUSE: r=0, g=1
  - DONE: r=1, g=1
- Priority, highest first: `rst`, then recount/set change, then start edge, then tick.

## Timing
- Reset values: count = 0, rounds = 0, state PAUSE.
  - seg_led = {DIGITS{9'h03f}}
  - count_led = all 1
  - status_led_r=0, status_led_g=1
  - done=0
  - breath_led=1
- A start edge at the pin changes state in the 3rd clk edge after it is first sampled high.
- The first tick after entering RUN comes DIV cycles later. Ticks are then periodic every DIV cycles.
- seg_led, count_led, status outputs and done are registered and lag the internal state by 1 cycle.
- A tick and a start edge in the same cycle: the start edge wins and the tick is dropped.
- Asserting `rst` mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- BREATH_LED_EN defined:
  - A PWM counter runs 0..BREATH_STEPS-1.
  - Duty steps ±1 per PWM period, ramping 0 up to BREATH_STEPS-1 and back.
  - breath_led = 0 while the PWM counter is less than the duty.
- BREATH_LED_EN undefined: no breath logic is built and breath_led is tied to 1.

## Test plan
- Reset: drive rst=0 mid-RUN -> all outputs take their reset values asynchronously; after release, the block stays in PAUSE with seg_led showing 00.
- Up, TICK_DIV=4, set=00 (preset 10): start pulse -> 00..10, then 00 on the 11th tick; count_led=8'b11111110; tick period is exactly 4 cycles.
- Down, set=01 (preset 24): start pulse -> 24, 23, ... 20 -> 19 (borrow), ... 00 -> 24; count_led=8'b11111110.
- Pause at 07: start pulse -> count frozen at 07 and r=0, g=1. Resume -> 08 appears exactly TICK_DIV cycles after re-entering RUN.
- ROUNDS=2, preset 10, up: after 22 ticks -> done=1, count 00, count_led=2'b00, r=g=1. A further start pulse -> rounds cleared and RUN resumes.
- Toggle recount mid-RUN at 05 -> next cycle the count is 10 (preset), rounds 0, PAUSE. With fast=1 and FAST_DIV=2, the tick period is 2 cycles.

Source files
------------

// File: rtl/bcd_round_timer_if.sv
// bcd_round_timer_if: button/switch inputs and display outputs of the BCD round timer
interface bcd_round_timer_if #(
    parameter int DIGITS = 2,
    parameter int ROUNDS = 8
);
    logic                  start;
    logic                  recount;
    logic [1:0]            set;
    logic                  fast;
    logic [9*DIGITS-1:0]   seg_led;
    logic [ROUNDS-1:0]     count_led;
    logic                  status_led_r;
    logic                  status_led_g;
    logic                  done;
    logic                  breath_led;

    modport master (
        output start, recount, set, fast,
        input  seg_led, count_led, status_led_r, status_led_g, done, breath_led
    );

    modport slave (
        input  start, recount, set, fast,
        output seg_led, count_led, status_led_r, status_led_g, done, breath_led
    );
endinterface

// File: rtl/bcd_round_timer.sv
// bcd_round_timer: up/down BCD round timer with preset select, round LEDs and status; breathing LED built only with BREATH_LED_EN
module bcd_round_timer #(
    parameter int                    TICK_DIV     = 6000000,
    parameter int                    FAST_DIV     = 1500000,
    parameter int                    DIGITS       = 2,
    parameter int                    ROUNDS       = 8,
    parameter logic [4*DIGITS-1:0]   PRESET0      = 'h10,
    parameter logic [4*DIGITS-1:0]   PRESET1      = 'h24,
    parameter logic [4*DIGITS-1:0]   PRESET2      = 'h60,
    parameter logic [4*DIGITS-1:0]   PRESET3      = 'h99,
    parameter int                    BREATH_STEPS = 4800
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_round_timer_if.slave     bus
);
    localparam int CW = 4 * DIGITS;
    localparam int DW = $clog2((TICK_DIV > FAST_DIV ? TICK_DIV : FAST_DIV) + 1);
    localparam int RW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {PAUSE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [RW-1:0]   rounds;
    logic [DW-1:0]   div;
    logic [1:0]      start_sy, rc_sy, fast_sy, set_sy1, set_sy2, set_d;
    logic            start_d, rc_d, fast_d;
    logic [CW-1:0]   preset, start_val;
    logic [DW-1:0]   div_max;
    logic            start_edge, cfg_chg, fast_chg, tick, wrap;

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
        clamp = v;
        for (int d = 0; d < DIGITS; d++)
            clamp[4*d+:4] = v[4*d+:4] > 4'd9 ? 4'd9 : v[4*d+:4];
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic c;
        bcd_inc = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (c) begin
                c = (v[4*d+:4] == 4'd9);
                bcd_inc[4*d+:4] = c ? 4'd0 : v[4*d+:4] + 4'd1;
            end
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic b;
        bcd_dec = v;
        b = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (b) begin
                b = (v[4*d+:4] == 4'd0);
                bcd_dec[4*d+:4] = b ? 4'd9 : v[4*d+:4] - 4'd1;
            end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3f;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5b;
            4'd3:    seg7 = 7'h4f;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6d;
            4'd6:    seg7 = 7'h7d;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7f;
            default: seg7 = 7'h6f;
        endcase
    endfunction

    assign preset     = clamp(set_sy2 == 2'd0 ? PRESET0 :
                              set_sy2 == 2'd1 ? PRESET1 :
                              set_sy2 == 2'd2 ? PRESET2 : PRESET3);
    assign start_val  = rc_sy[1] ? preset : '0;
    assign div_max    = fast_sy[1] ? DW'(FAST_DIV - 1) : DW'(TICK_DIV - 1);
    assign start_edge = start_sy[1] & ~start_d;
    assign cfg_chg    = (rc_sy[1] != rc_d) | (set_sy2 != set_d);
    assign fast_chg   = fast_sy[1] != fast_d;
    assign tick       = (state == RUN) && (div == div_max);
    assign wrap       = rc_sy[1] ? (count == '0) : (count == preset);

    // two-flop synchronizers plus one delayed copy for edge/change detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_sy <= '0;
            rc_sy    <= '0;
            fast_sy  <= '0;
            set_sy1  <= '0;
            set_sy2  <= '0;
            start_d  <= 1'b0;
            rc_d     <= 1'b0;
            fast_d   <= 1'b0;
            set_d    <= '0;
        end else begin
            start_sy <= {start_sy[0], bus.start};
            rc_sy    <= {rc_sy[0], bus.recount};
            fast_sy  <= {fast_sy[0], bus.fast};
            set_sy1  <= bus.set;
            set_sy2  <= set_sy1;
            start_d  <= start_sy[1];
            rc_d     <= rc_sy[1];
            fast_d   <= fast_sy[1];
            set_d    <= set_sy2;
        end
    end

    // run/pause/done control with config reload > start edge > tick priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= PAUSE;
            count  <= '0;
            rounds <= '0;
            div    <= '0;
        end else if (cfg_chg) begin
            state  <= PAUSE;
            count  <= start_val;
            rounds <= '0;
            div    <= '0;
        end else if (start_edge) begin
            div <= '0;
            if (state == RUN)
                state <= PAUSE;
            else begin
                state <= RUN;
                if (state == DONE) begin
                    count  <= start_val;
                    rounds <= '0;
                end
            end
        end else if (state == RUN) begin
            div <= (tick || fast_chg) ? '0 : div + DW'(1);
            if (tick && wrap) begin
                count  <= rc_sy[1] ? preset : '0;
                rounds <= rounds + RW'(1);
                if (rounds == RW'(ROUNDS - 1))
                    state <= DONE;
            end else if (tick)
                count <= rc_sy[1] ? bcd_dec(count) : bcd_inc(count);
        end
    end

    // registered display, round bar and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.seg_led      <= {DIGITS{9'h03f}};
            bus.count_led    <= '1;
            bus.status_led_r <= 1'b0;
            bus.status_led_g <= 1'b1;
            bus.done         <= 1'b0;
        end else begin
            for (int d = 0; d < DIGITS; d++)
                bus.seg_led[9*d+:9] <= {2'b00, seg7(count[4*d+:4])};
            for (int i = 0; i < ROUNDS; i++)
                bus.count_led[i] <= rounds <= RW'(i);
            bus.status_led_r <= state != PAUSE;
            bus.status_led_g <= state != RUN;
            bus.done         <= state == DONE;
        end
    end

`ifdef BREATH_LED_EN
    localparam int BW = $clog2(BREATH_STEPS);

    logic [BW-1:0] pwm, duty;
    logic          ramp_up;

    // PWM period counter and triangular duty ramp, one duty step per period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm     <= '0;
            duty    <= '0;
            ramp_up <= 1'b1;
        end else begin
            pwm <= (pwm == BW'(BREATH_STEPS - 1)) ? '0 : pwm + BW'(1);
            if (pwm == BW'(BREATH_STEPS - 1)) begin
                ramp_up <= ramp_up ? (duty != BW'(BREATH_STEPS - 2)) : (duty == BW'(1));
                duty    <= ramp_up ? duty + BW'(1) : duty - BW'(1);
            end
        end
    end

    assign bus.breath_led = !(pwm < duty);
`else
    assign bus.breath_led = 1'b1;
`endif
endmodule
